// File: rtl/fetch_stage.sv
// IF stage: PC register, next-PC select, IF/ID pipeline register.
// Define FETCH_PERF_EN to build the fetch_count/bubble_count performance counters.
module fetch_stage #(
  parameter logic [31:0] PC_RESET   = 32'h0000_0000,
  parameter int          IMEM_WORDS = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ifid_instru,
  output logic [31:0] ifid_pc,
  output logic        ifid_valid,
  output logic [31:0] fetch_count,
  output logic [31:0] bubble_count
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] instru_q, instru_d;
  logic [31:0] ifid_pc_q, ifid_pc_d;
  logic        valid_q, valid_d;
  logic        in_range;
  logic        advance;
  logic [31:0] fetch_word;

  // Words past the end of instruction memory still count as fetched, but read as NOP.
  assign in_range   = ({2'b00, pc_q[31:2]} < 32'(IMEM_WORDS));
  assign fetch_word = in_range ? imem_rdata : 32'h0;
  assign advance    = !redirect && !stall;
  assign imem_addr  = pc_q;

  always_comb begin
    pc_d      = pc_q;
    instru_d  = instru_q;
    ifid_pc_d = ifid_pc_q;
    valid_d   = valid_q;
    if (redirect) begin
      pc_d      = redirect_pc & 32'hFFFF_FFFC;
      instru_d  = 32'h0;
      ifid_pc_d = 32'h0;
      valid_d   = 1'b0;
    end else if (!stall) begin
      pc_d      = pc_q + 32'd4;
      instru_d  = fetch_word;
      ifid_pc_d = pc_q;
      valid_d   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q      <= PC_RESET;
      instru_q  <= 32'h0;
      ifid_pc_q <= 32'h0;
      valid_q   <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      instru_q  <= instru_d;
      ifid_pc_q <= ifid_pc_d;
      valid_q   <= valid_d;
    end
  end

  assign ifid_instru = instru_q;
  assign ifid_pc     = ifid_pc_q;
  assign ifid_valid  = valid_q;

`ifdef FETCH_PERF_EN
  logic [31:0] fetch_count_q, fetch_count_d;
  logic [31:0] bubble_count_q, bubble_count_d;

  always_comb begin
    fetch_count_d  = fetch_count_q + (advance ? 32'd1 : 32'd0);
    bubble_count_d = bubble_count_q + (redirect ? 32'd1 : 32'd0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_count_q  <= 32'h0;
      bubble_count_q <= 32'h0;
    end else begin
      fetch_count_q  <= fetch_count_d;
      bubble_count_q <= bubble_count_d;
    end
  end

  assign fetch_count  = fetch_count_q;
  assign bubble_count = bubble_count_q;
`else
  logic unused_advance;
  assign unused_advance = advance;
  assign fetch_count    = 32'h0;
  assign bubble_count   = 32'h0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus a randomized run
// against a cycle-level reference model of the PC / IF-ID register.
module tb_fetch_stage;

  localparam int WORDS = 16;
`ifdef FETCH_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, stall, redirect;
  logic [31:0] redirect_pc, imem_addr, imem_rdata;
  logic [31:0] ifid_instru, ifid_pc, fetch_count, bubble_count;
  logic        ifid_valid;

  logic [31:0] mem [256];
  assign imem_rdata = mem[imem_addr[9:2]];

  fetch_stage #(.PC_RESET(32'h0), .IMEM_WORDS(WORDS)) dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .ifid_instru(ifid_instru), .ifid_pc(ifid_pc), .ifid_valid(ifid_valid),
    .fetch_count(fetch_count), .bubble_count(bubble_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [31:0] m_pc, m_instr, m_ipc, m_fc, m_bc;
  logic        m_valid;

  function automatic logic [31:0] exp_cnt(input logic [31:0] v);
    return PERF ? v : 32'h0;
  endfunction

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return (a / 4 < WORDS) ? mem[a[9:2]] : 32'h0;
  endfunction

  // Apply one clock edge with the given inputs, advancing the model in step.
  task automatic edge_in(input logic r, input logic st, input logic rd, input logic [31:0] rpc);
    @(negedge clk);
    rst = r; stall = st; redirect = rd; redirect_pc = rpc;
    @(posedge clk);
    if (r) begin
      m_pc = 32'h0; m_instr = 0; m_ipc = 0; m_valid = 0; m_fc = 0; m_bc = 0;
    end else if (rd) begin
      m_pc = {rpc[31:2], 2'b00}; m_instr = 0; m_ipc = 0; m_valid = 0; m_bc = m_bc + 1;
    end else if (!st) begin
      m_instr = word_at(m_pc); m_ipc = m_pc; m_valid = 1; m_fc = m_fc + 1;
      m_pc = m_pc + 4;
    end
    #1;
  endtask

  task automatic test_reset();
    edge_in(1, 1, 1, 32'h40);
    edge_in(1, 0, 0, 32'h0);
    n_checks++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL reset_pc got %h want %h", imem_addr, 32'h0); end
    n_checks++; if (ifid_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", ifid_valid); end
    n_checks++; if (ifid_instru !== 32'h0 || ifid_pc !== 32'h0) begin n_fail++; $display("FAIL reset_ifid got %h/%h want 0/0", ifid_instru, ifid_pc); end
    n_checks++; if (fetch_count !== 32'h0 || bubble_count !== 32'h0) begin n_fail++; $display("FAIL reset_cnt got %h/%h want 0/0", fetch_count, bubble_count); end
  endtask

  task automatic test_sequential();
    for (int i = 0; i < 4; i++) begin
      edge_in(0, 0, 0, 32'h0);
      n_checks++; if (ifid_pc !== 32'(4 * i) || ifid_valid !== 1'b1) begin n_fail++; $display("FAIL seq_pc%0d got %h/%b want %h/1", i, ifid_pc, ifid_valid, 32'(4 * i)); end
      n_checks++; if (ifid_instru !== mem[i]) begin n_fail++; $display("FAIL seq_instr%0d got %h want %h", i, ifid_instru, mem[i]); end
    end
    n_checks++; if (fetch_count !== exp_cnt(32'd4)) begin n_fail++; $display("FAIL seq_fcount got %h want %h", fetch_count, exp_cnt(32'd4)); end
  endtask

  task automatic test_stall();
    edge_in(1, 0, 0, 0);
    edge_in(0, 0, 0, 0);
    edge_in(0, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      edge_in(0, 1, 0, 0);
      n_checks++; if (imem_addr !== 32'h8 || ifid_pc !== 32'h4) begin n_fail++; $display("FAIL stall_hold%0d got pc %h ifid_pc %h want 8/4", i, imem_addr, ifid_pc); end
    end
    n_checks++; if (fetch_count !== exp_cnt(32'd2)) begin n_fail++; $display("FAIL stall_fcount got %h want %h", fetch_count, exp_cnt(32'd2)); end
    edge_in(0, 0, 0, 0);
    n_checks++; if (ifid_pc !== 32'h8 || ifid_instru !== mem[2]) begin n_fail++; $display("FAIL stall_release got %h/%h want 8/%h", ifid_pc, ifid_instru, mem[2]); end
  endtask

  task automatic test_redirect();
    // pc is now 0xC
    edge_in(0, 0, 1, 32'h43);
    n_checks++; if (imem_addr !== 32'h40) begin n_fail++; $display("FAIL redir_pc got %h want 40", imem_addr); end
    n_checks++; if (ifid_valid !== 1'b0 || ifid_instru !== 32'h0 || ifid_pc !== 32'h0) begin n_fail++; $display("FAIL redir_bubble got %b/%h/%h want 0/0/0", ifid_valid, ifid_instru, ifid_pc); end
    edge_in(0, 0, 0, 0);
    n_checks++; if (ifid_pc !== 32'h40 || ifid_valid !== 1'b1) begin n_fail++; $display("FAIL redir_next got %h/%b want 40/1", ifid_pc, ifid_valid); end
    n_checks++; if (bubble_count !== exp_cnt(32'd1)) begin n_fail++; $display("FAIL redir_bcount got %h want %h", bubble_count, exp_cnt(32'd1)); end
    // redirect with stall: redirect wins
    edge_in(0, 1, 1, 32'h1E);
    n_checks++; if (imem_addr !== 32'h1C || ifid_valid !== 1'b0) begin n_fail++; $display("FAIL redir_stall got %h/%b want 1c/0", imem_addr, ifid_valid); end
    n_checks++; if (bubble_count !== exp_cnt(32'd2)) begin n_fail++; $display("FAIL redir_stall_bcount got %h want %h", bubble_count, exp_cnt(32'd2)); end
  endtask

  task automatic test_out_of_range();
    edge_in(0, 0, 1, 32'h38);
    for (int i = 0; i < 4; i++) begin
      edge_in(0, 0, 0, 0);
      n_checks++;
      if (ifid_pc !== 32'(32'h38 + 4 * i) || ifid_valid !== 1'b1 || ifid_instru !== ((i < 2) ? mem[14 + i] : 32'h0)) begin
        n_fail++; $display("FAIL oor%0d got %h/%h/%b", i, ifid_pc, ifid_instru, ifid_valid);
      end
    end
    n_checks++; if (imem_addr !== 32'h48) begin n_fail++; $display("FAIL oor_pc got %h want 48", imem_addr); end
  endtask

  task automatic test_wrap();
    edge_in(0, 0, 1, 32'hFFFF_FFF9);
    edge_in(0, 0, 0, 0);
    edge_in(0, 0, 0, 0);
    n_checks++; if (imem_addr !== 32'h0 || ifid_pc !== 32'hFFFF_FFFC || ifid_instru !== 32'h0) begin n_fail++; $display("FAIL wrap got %h/%h/%h want 0/fffffffc/0", imem_addr, ifid_pc, ifid_instru); end
  endtask

  task automatic test_reset_mid_stall();
    edge_in(0, 0, 1, 32'h20);
    edge_in(0, 1, 0, 0);
    edge_in(1, 1, 1, 32'h60);
    n_checks++; if (imem_addr !== 32'h0 || ifid_valid !== 1'b0 || ifid_pc !== 32'h0) begin n_fail++; $display("FAIL rst_stall got %h/%b/%h want 0/0/0", imem_addr, ifid_valid, ifid_pc); end
    n_checks++; if (fetch_count !== 32'h0 || bubble_count !== 32'h0) begin n_fail++; $display("FAIL rst_stall_cnt got %h/%h want 0/0", fetch_count, bubble_count); end
  endtask

  task automatic test_random();
    logic r, st, rd;
    logic [31:0] rpc;
    for (int i = 0; i < 400; i++) begin
      r   = ($urandom_range(0, 39) == 0);
      st  = ($urandom_range(0, 3) == 0);
      rd  = ($urandom_range(0, 5) == 0);
      rpc = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 127));
      edge_in(r, st, rd, rpc);
      n_checks++;
      if (imem_addr !== m_pc || ifid_instru !== m_instr || ifid_pc !== m_ipc || ifid_valid !== m_valid) begin
        n_fail++; $display("FAIL rand%0d got pc %h ifid %h/%h/%b want %h %h/%h/%b", i, imem_addr, ifid_instru, ifid_pc, ifid_valid, m_pc, m_instr, m_ipc, m_valid);
      end
      n_checks++;
      if (fetch_count !== exp_cnt(m_fc) || bubble_count !== exp_cnt(m_bc)) begin
        n_fail++; $display("FAIL rand_cnt%0d got %h/%h want %h/%h", i, fetch_count, bubble_count, exp_cnt(m_fc), exp_cnt(m_bc));
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = $urandom | 32'h1;
    rst = 1; stall = 0; redirect = 0; redirect_pc = 0;
    m_pc = 0; m_instr = 0; m_ipc = 0; m_valid = 0; m_fc = 0; m_bc = 0;
    test_reset();
    test_sequential();
    test_stall();
    test_redirect();
    test_out_of_range();
    test_wrap();
    test_reset_mid_stall();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
